nco_poly: RTL and testbench
===========================

Name: nco_poly

Overview:
- Parametrised, time-multiplexed polyphonic successor to the single-voice NCO.
- NUM_VOICES phase accumulators share one adder; one voice is serviced per clock, in strict round-robin order.
- Emits a registered waveram address of {voice index, wave select, phase MSBs} each cycle for the shared waveram.
- Host writes a tuning word, wave select and optional phase reset to any voice through a single latch port.

Parameters:
NUM_VOICES, 4, number of voices; power of two, >= 2
FTW_WIDTH, 26, frequency tuning word width
ACC_WIDTH, 32, phase accumulator width; must be >= FTW_WIDTH
ADDR_WIDTH, 12, phase bits sent to waveram (accumulator MSBs)
WAVE_SEL_WIDTH, 2, wave select width
VIDX_WIDTH, $clog2(NUM_VOICES), voice index width (derived, localparam)

Ports:
i_clock  in  1  system clock
i_reset_n  in  1  asynchronous, active-low reset
i_input_latch_write_enable  in  1  latch write strobe; sampled every rising edge
i_write_voice  in  VIDX_WIDTH  target voice of the write
i_ftw  in  FTW_WIDTH  tuning word, zero-extended into the accumulator
i_wave_sel  in  WAVE_SEL_WIDTH  waveform select for the target voice
i_phase_reset  in  1  with a write: zero the target voice's phase at its next service
o_waveram_address  out  VIDX_WIDTH+WAVE_SEL_WIDTH+ADDR_WIDTH  {voice, wave_sel, acc[ACC_WIDTH-1 -: ADDR_WIDTH]}
o_voice  out  VIDX_WIDTH  voice that produced the current address
o_valid  out  1  address valid
o_wrap  out  1  one-cycle pulse: the serviced voice's accumulator carried out

Behaviour:
- Reset (async assert, sync release):
  - all accumulators, shadow and active FTW/wave_sel registers, and pending flags clear to 0;
  - service counter clears to 0;
  - every output clears to 0.
  - Reset asserted mid-operation clears everything immediately, with no clock needed.
- Service counter:
  - increments by 1 each clock and wraps NUM_VOICES-1 -> 0.
  - The first edge after reset release services voice 0.
- Writes (shadow latch):
  - On an edge with write enable high, shadow[i_write_voice] <= {i_ftw, i_wave_sel}.
  - If i_phase_reset is high, pending_reset[i_write_voice] <= 1.
  - Consecutive-cycle writes are all accepted; the last write to a voice before its service wins.
- Service of voice v at edge k:
  - active[v] <= shadow[v], as it stood before edge k.
  - If pending_reset[v] is set: acc[v] <= 0, pending_reset[v] <= 0, o_wrap <= 0.
  - Otherwise: {carry, acc[v]} <= acc[v] + active[v].ftw; o_wrap <= carry.
  - The output uses the values produced at edge k (new acc, new wave_sel): o_waveram_address <= {v, active.wave_sel, new acc MSBs}; o_voice <= v; o_valid <= 1.
  - Latency: write to first effect is at most NUM_VOICES+1 edges.
- Write to a voice on the same edge as its service: the service uses the prior shadow; the new value takes effect at the voice's next service, one round later. A phase reset written on the same edge takes effect at the next service.
- Accumulator arithmetic is modulo 2^ACC_WIDTH.
- FTW = 0 freezes phase: the address holds, and o_wrap never pulses for that voice.
- o_valid is 1 every cycle after the first post-reset edge.

Optional Feature:
- Macro: NCO_POLY_HARD_SYNC_EN.
- Defined:
  - Adds port i_sync_mask, input, NUM_VOICES bits.
  - When voice 0's service produces carry, every voice v >= 1 with i_sync_mask[v] set gets its pending_reset set; it restarts at phase 0 on its next service.
  - If a host write sets pending_reset on the same edge, the effect is identical (the flag is set once).
  - Mask bit 0 is ignored.
- Undefined: the port is absent, with no sync logic or extra registers; behaviour is otherwise identical.

Test Plan:
1. Hold i_reset_n low for 3 clocks -> all outputs 0. Release -> o_voice 0,1,2,3,0,... on consecutive edges; o_valid 1 from the first edge; all address phase fields 0.
2. Write voice 1, FTW=0x100000 (2^20), wave_sel=0 -> voice 1's phase field increments by 1 every 4 clocks. After 4096 services it reads 0 with o_wrap=1 for exactly that cycle.
3. Write voice 2 with wave_sel=3 -> voice 2 address bits [13:12]=2'b11 from its next service onward; other voices unchanged.
4. Voice 1 running at phase field 0x2A0; write FTW unchanged with i_phase_reset=1 -> at its next service the address is 16'h4000 ({01,00,0x000}); advance resumes the following round.
5. Write voice 3 with FTW=0x200000 on the same edge voice 3 is serviced -> that service adds the old FTW; the next round adds 0x200000.
6. With NCO_POLY_HARD_SYNC_EN defined, mask=4'b0100, voice 0 FTW=0x3000000, voice 2 FTW=0x100000 -> on each voice-0 o_wrap, voice 2's next service outputs phase field 0. Voice 1 is unaffected.

Source files
------------

// File: rtl/nco_poly.sv
// Time-multiplexed polyphonic NCO: NUM_VOICES phase accumulators share one adder, serviced round-robin.
// Optional hard sync of masked voices to voice 0's wrap is enabled by defining NCO_POLY_HARD_SYNC_EN.
module nco_poly #(
    parameter int NUM_VOICES     = 4,
    parameter int FTW_WIDTH      = 26,
    parameter int ACC_WIDTH      = 32,
    parameter int ADDR_WIDTH     = 12,
    parameter int WAVE_SEL_WIDTH = 2,
    localparam int VIDX_WIDTH    = $clog2(NUM_VOICES),
    localparam int OUT_WIDTH     = VIDX_WIDTH + WAVE_SEL_WIDTH + ADDR_WIDTH
) (
    input  logic                      i_clock,
    input  logic                      i_reset_n,
    input  logic                      i_input_latch_write_enable,
    input  logic [VIDX_WIDTH-1:0]     i_write_voice,
    input  logic [FTW_WIDTH-1:0]      i_ftw,
    input  logic [WAVE_SEL_WIDTH-1:0] i_wave_sel,
    input  logic                      i_phase_reset,
`ifdef NCO_POLY_HARD_SYNC_EN
    input  logic [NUM_VOICES-1:0]     i_sync_mask,
`endif
    output logic [OUT_WIDTH-1:0]      o_waveram_address,
    output logic [VIDX_WIDTH-1:0]     o_voice,
    output logic                      o_valid,
    output logic                      o_wrap
);

    typedef struct packed {
        logic [FTW_WIDTH-1:0]      ftw;
        logic [WAVE_SEL_WIDTH-1:0] wave_sel;
    } voice_cfg_t;

    logic [VIDX_WIDTH-1:0] svc;
    logic [ACC_WIDTH-1:0]  acc    [NUM_VOICES];
    voice_cfg_t            shadow [NUM_VOICES];
    voice_cfg_t            active [NUM_VOICES];
    logic [NUM_VOICES-1:0] dirty;
    logic [NUM_VOICES-1:0] pending;

    voice_cfg_t            cfg;
    logic [ACC_WIDTH:0]    sum;
    logic [ACC_WIDTH-1:0]  acc_next;
    logic                  carry;
    logic [NUM_VOICES-1:0] svc_onehot;
    logic [NUM_VOICES-1:0] write_onehot;
    logic [NUM_VOICES-1:0] dirty_next;
    logic [NUM_VOICES-1:0] pending_next;
`ifdef NCO_POLY_HARD_SYNC_EN
    logic [NUM_VOICES-1:0] sync_set;
`endif

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        svc_onehot        = '0;
        svc_onehot[svc]   = 1'b1;
        write_onehot      = '0;
        if (i_input_latch_write_enable)
            write_onehot[i_write_voice] = 1'b1;

        // A voice with an uncommitted shadow write takes the shadow; otherwise its committed copy.
        cfg = dirty[svc] ? shadow[svc] : active[svc];
        sum = {1'b0, acc[svc]} + (ACC_WIDTH+1)'(cfg.ftw);

        if (pending[svc]) begin
            acc_next = '0;
            carry    = 1'b0;
        end else begin
            acc_next = sum[ACC_WIDTH-1:0];
            carry    = sum[ACC_WIDTH];
        end

        // Host writes are ORed in after the service clear, so a same-edge write survives.
        dirty_next = (dirty & ~svc_onehot) | write_onehot;
`ifdef NCO_POLY_HARD_SYNC_EN
        sync_set = '0;
        if (svc == '0 && carry) begin
            sync_set    = i_sync_mask;
            sync_set[0] = 1'b0;
        end
        pending_next = (pending & ~svc_onehot) | sync_set
                     | (i_phase_reset ? write_onehot : '0);
`else
        pending_next = (pending & ~svc_onehot)
                     | (i_phase_reset ? write_onehot : '0);
`endif
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            // NOTE: per-voice state lives in flops, not RAM, so every entry is cleared in reset.
            for (int v = 0; v < NUM_VOICES; v++) begin
                acc[v]    <= '0;
                shadow[v] <= '0;
                active[v] <= '0;
            end
            dirty             <= '0;
            pending           <= '0;
            svc               <= '0;
            o_waveram_address <= '0;
            o_voice           <= '0;
            o_valid           <= 1'b0;
            o_wrap            <= 1'b0;
        end else begin
            // NOTE: non-blocking updates, so all reads this edge see pre-edge state.
            svc         <= svc + 1'b1;
            acc[svc]    <= acc_next;
            active[svc] <= cfg;
            if (i_input_latch_write_enable)
                shadow[i_write_voice] <= {i_ftw, i_wave_sel};
            dirty   <= dirty_next;
            pending <= pending_next;

            o_waveram_address <= {svc, cfg.wave_sel, acc_next[ACC_WIDTH-1 -: ADDR_WIDTH]};
            o_voice           <= svc;
            o_valid           <= 1'b1;
            o_wrap            <= carry;
        end
    end

endmodule

// File: tb/tb_nco_poly.sv
// Self-checking bench for nco_poly: reset checks, a directed vector table, multi-cycle corner
// sequences and randomized writes compared against a per-voice phase model.
module tb_nco_poly;

    localparam int NV  = 4;
    localparam int FW  = 26;
    localparam int AW  = 32;
    localparam int ADW = 12;
    localparam int WSW = 2;
    localparam int VW  = 2;
    localparam int OW  = VW + WSW + ADW;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           we = 1'b0;
    logic [VW-1:0]  wv = '0;
    logic [FW-1:0]  ftw = '0;
    logic [WSW-1:0] ws = '0;
    logic           pr = 1'b0;
`ifdef NCO_POLY_HARD_SYNC_EN
    logic [NV-1:0]  sync_mask = '0;
`endif
    logic [OW-1:0]  o_waveram_address;
    logic [VW-1:0]  o_voice;
    logic           o_valid;
    logic           o_wrap;

    nco_poly dut (
        .i_clock                   (clk),
        .i_reset_n                 (rst_n),
        .i_input_latch_write_enable(we),
        .i_write_voice             (wv),
        .i_ftw                     (ftw),
        .i_wave_sel                (ws),
        .i_phase_reset             (pr),
`ifdef NCO_POLY_HARD_SYNC_EN
        .i_sync_mask               (sync_mask),
`endif
        .o_waveram_address         (o_waveram_address),
        .o_voice                   (o_voice),
        .o_valid                   (o_valid),
        .o_wrap                    (o_wrap)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: phase per voice as a plain integer modulo 2^AW.
    longint unsigned m_phase [NV];
    logic [FW-1:0]   m_ftw   [NV];
    logic [WSW-1:0]  m_ws    [NV];
    bit              m_pend  [NV];
    int              m_cycle;
    logic [OW-1:0]   e_addr;
    logic [VW-1:0]   e_voice;
    logic            e_wrap;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NV; i++) begin
            m_phase[i] = 0;
            m_ftw[i]   = '0;
            m_ws[i]    = '0;
            m_pend[i]  = 1'b0;
        end
        m_cycle = 0;
    endtask

    task automatic model_edge(input logic c_we, input logic [VW-1:0] c_wv, input logic [FW-1:0] c_ftw,
                              input logic [WSW-1:0] c_ws, input logic c_pr, input logic [NV-1:0] c_mask);
        int v;
        longint unsigned s;
        longint unsigned modulus;
        modulus = 64'd1 << AW;
        v = m_cycle % NV;
        if (m_pend[v]) begin
            m_phase[v] = 0;
            m_pend[v]  = 1'b0;
            e_wrap     = 1'b0;
        end else begin
            s          = m_phase[v] + 64'(m_ftw[v]);
            e_wrap     = (s >= modulus);
            m_phase[v] = s % modulus;
        end
        e_voice = VW'(v);
        e_addr  = {VW'(v), m_ws[v], ADW'(m_phase[v] >> (AW - ADW))};
        if (v == 0 && e_wrap)
            for (int u = 1; u < NV; u++)
                if (c_mask[u]) m_pend[u] = 1'b1;
        if (c_we) begin
            m_ftw[c_wv] = c_ftw;
            m_ws[c_wv]  = c_ws;
            if (c_pr) m_pend[c_wv] = 1'b1;
        end
        m_cycle++;
    endtask

    task automatic step();
        logic           c_we  = we;
        logic [VW-1:0]  c_wv  = wv;
        logic [FW-1:0]  c_ftw = ftw;
        logic [WSW-1:0] c_ws  = ws;
        logic           c_pr  = pr;
        logic [NV-1:0]  c_mask;
`ifdef NCO_POLY_HARD_SYNC_EN
        c_mask = sync_mask;
`else
        c_mask = '0;
`endif
        @(posedge clk);
        #1;
        model_edge(c_we, c_wv, c_ftw, c_ws, c_pr, c_mask);
        check("model_voice", o_voice, e_voice);
        check("model_addr", o_waveram_address, e_addr);
        check("model_wrap", o_wrap, e_wrap);
        check("valid", o_valid, 1);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_addr"}, o_waveram_address, 0);
        check({tag, "_voice"}, o_voice, 0);
        check({tag, "_valid"}, o_valid, 0);
        check({tag, "_wrap"}, o_wrap, 0);
    endtask

    typedef struct {
        logic           we;
        logic [VW-1:0]  wv;
        logic [FW-1:0]  ftw;
        logic [WSW-1:0] ws;
        logic           pr;
        logic [VW-1:0]  ev;
        logic [OW-1:0]  ea;
        logic           ew;
    } vec_t;

    vec_t tbl [14];
    int   wraps;

    initial begin
        tbl[0]  = '{1'b1, 2'd0, 26'h1000000, 2'd1, 1'b0, 2'd0, 16'h0000, 1'b0};
        tbl[1]  = '{1'b1, 2'd1, 26'h0100000, 2'd2, 1'b0, 2'd1, 16'h4000, 1'b0};
        tbl[2]  = '{1'b0, 2'd0, 26'h0,       2'd0, 1'b0, 2'd2, 16'h8000, 1'b0};
        tbl[3]  = '{1'b1, 2'd3, 26'h3FFFFFF, 2'd3, 1'b0, 2'd3, 16'hC000, 1'b0};
        tbl[4]  = '{1'b0, 2'd0, 26'h0,       2'd0, 1'b0, 2'd0, 16'h1010, 1'b0};
        tbl[5]  = '{1'b0, 2'd0, 26'h0,       2'd0, 1'b0, 2'd1, 16'h6001, 1'b0};
        tbl[6]  = '{1'b0, 2'd0, 26'h0,       2'd0, 1'b0, 2'd2, 16'h8000, 1'b0};
        tbl[7]  = '{1'b0, 2'd0, 26'h0,       2'd0, 1'b0, 2'd3, 16'hF03F, 1'b0};
        tbl[8]  = '{1'b1, 2'd0, 26'h1000000, 2'd1, 1'b1, 2'd0, 16'h1020, 1'b0};
        tbl[9]  = '{1'b0, 2'd0, 26'h0,       2'd0, 1'b0, 2'd1, 16'h6002, 1'b0};
        tbl[10] = '{1'b0, 2'd0, 26'h0,       2'd0, 1'b0, 2'd2, 16'h8000, 1'b0};
        tbl[11] = '{1'b0, 2'd0, 26'h0,       2'd0, 1'b0, 2'd3, 16'hF07F, 1'b0};
        tbl[12] = '{1'b0, 2'd0, 26'h0,       2'd0, 1'b0, 2'd0, 16'h1000, 1'b0};
        tbl[13] = '{1'b0, 2'd0, 26'h0,       2'd0, 1'b0, 2'd1, 16'h6003, 1'b0};

        // Reset held for three clocks.
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        model_reset();
        rst_n = 1'b1;

        // Directed table from the first post-reset edge.
        for (int i = 0; i < 14; i++) begin
            we = tbl[i].we; wv = tbl[i].wv; ftw = tbl[i].ftw; ws = tbl[i].ws; pr = tbl[i].pr;
            step();
            check($sformatf("tbl%0d_voice", i), o_voice, tbl[i].ev);
            check($sformatf("tbl%0d_addr", i), o_waveram_address, tbl[i].ea);
            check($sformatf("tbl%0d_wrap", i), o_wrap, tbl[i].ew);
        end
        we = 1'b0; pr = 1'b0;

        // Asynchronous reset mid-operation: outputs clear with no clock edge.
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_outputs_zero("async_reset");
        @(posedge clk);
        #1;
        model_reset();
        rst_n = 1'b1;

        // Voice 1 at FTW 2^20: exactly one wrap across ~4098 services.
        we = 1'b1; wv = 2'd1; ftw = 26'h0100000; ws = 2'd0; pr = 1'b0;
        step();
        we = 1'b0;
        wraps = 0;
        repeat (4096 * NV + 8) begin
            step();
            if (o_voice == 2'd1 && o_wrap) wraps++;
        end
        check("v1_wrap_count", wraps, 1);

        // Phase reset on voice 1, written on the edge that services voice 3.
        while (m_cycle % NV != 3) step();
        we = 1'b1; wv = 2'd1; ftw = 26'h0100000; ws = 2'd0; pr = 1'b1;
        step();
        we = 1'b0; pr = 1'b0;
        for (int k = 0; k < NV; k++) begin
            step();
            if (o_voice == 2'd1) break;
        end
        check("phase_reset_addr", o_waveram_address, 16'h4000);
        repeat (NV) step();
        check("phase_reset_resume", o_waveram_address, 16'h4001);

        // FTW write to voice 3 on the same edge voice 3 is serviced.
        while (m_cycle % NV != 3) step();
        we = 1'b1; wv = 2'd3; ftw = 26'h0200000; ws = 2'd0; pr = 1'b0;
        step();
        we = 1'b0;
        check("same_edge_old_ftw", o_waveram_address, 16'hC000);
        repeat (NV) step();
        check("same_edge_new_ftw", o_waveram_address, 16'hC002);

        // Randomized writes against the model.
`ifdef NCO_POLY_HARD_SYNC_EN
        sync_mask = NV'($urandom);
`endif
        repeat (3000) begin
            we = ($urandom_range(0, 2) == 0);
            wv = VW'($urandom_range(0, NV - 1));
            case ($urandom_range(0, 3))
                0: ftw = '0;
                1: ftw = FW'($urandom_range(1, 15)) << 20;
                2: ftw = FW'($urandom);
                default: ftw = 26'h3FFFFFF - FW'($urandom_range(0, 255));
            endcase
            ws = WSW'($urandom);
            pr = ($urandom_range(0, 7) == 0);
`ifdef NCO_POLY_HARD_SYNC_EN
            if ($urandom_range(0, 255) == 0) sync_mask = NV'($urandom);
`endif
            step();
        end
        we = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
